// File: rtl/rc4_ksa_if.sv
// -----------------------------------------------------------------------------
// rc4_ksa_if
// Bundle between the RC4 key-scheduling engine, the key-search controller and
// the single-port synchronous S-array RAM.
//
// Parameters
//   ADDR_W     S-array address and data width (DEPTH = 2**ADDR_W)
//   KEY_BYTES  secret key length in bytes
//
// Signals
//   start       controller -> engine  request a KSA run
//   secret_key  controller -> engine  key, byte 0 in the most significant byte
//   q           RAM        -> engine  RAM read data
//   address     engine     -> RAM     RAM address
//   data        engine     -> RAM     RAM write data
//   wren        engine     -> RAM     RAM write enable
//   busy        engine     -> ctrl    run in progress (including the DONE cycle)
//   finish      engine     -> ctrl    one-cycle completion pulse
//
// Modports
//   master  controller/RAM side (drives start, secret_key, q)
//   slave   engine side
// -----------------------------------------------------------------------------
interface rc4_ksa_if #(
    parameter int ADDR_W    = 8,
    parameter int KEY_BYTES = 3
);
    logic                   start;
    logic [KEY_BYTES*8-1:0] secret_key;
    logic [ADDR_W-1:0]      q;
    logic [ADDR_W-1:0]      address;
    logic [ADDR_W-1:0]      data;
    logic                   wren;
    logic                   busy;
    logic                   finish;

    modport master (
        output start,
        output secret_key,
        output q,
        input  address,
        input  data,
        input  wren,
        input  busy,
        input  finish
    );

    modport slave (
        input  start,
        input  secret_key,
        input  q,
        output address,
        output data,
        output wren,
        output busy,
        output finish
    );
endinterface

// File: rtl/rc4_ksa_engine.sv
// -----------------------------------------------------------------------------
// rc4_ksa_engine
// Parametrised RC4 key-scheduling engine working on an external single-port
// synchronous S-array RAM:
//     for i = 0..DEPTH-1: j = j + S[i] + key[i mod KEY_BYTES]; swap S[i], S[j]
//
// Parameters
//   ADDR_W     S-array address/data width, DEPTH = 2**ADDR_W
//   KEY_BYTES  secret key length in bytes (1 is legal)
//   RD_LAT     RAM read latency in cycles, 1..4
//
// Ports
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      rc4_ksa_if.slave: start, secret_key, q in; address, data, wren,
//            busy, finish out (all outputs registered)
//
// Build option
//   RC4_KSA_INIT_FILL_EN  when defined, each run begins with an INIT phase that
//                         writes S[n] = n for every n (one write per cycle);
//                         when undefined the array must be pre-filled externally.
//
// Iteration timing (one iteration = 2*RD_LAT+4 cycles):
//   RI      address = i on the bus
//   WAIT_I  RD_LAT-1 cycles
//   CI      S[i] arrives on q; j updated, address <= new j
//   WAIT_J  RD_LAT cycles (the j address reaches the RAM one cycle after CI)
//   CJ      S[j] arrives on q; set up write of S[j] to i
//   WI      write S[j] -> address i
//   WJ      write S[i] -> address j; advance i/k or go to DONE
// -----------------------------------------------------------------------------
module rc4_ksa_engine #(
    parameter int ADDR_W    = 8,
    parameter int KEY_BYTES = 3,
    parameter int RD_LAT    = 1
) (
    input  logic     clk,
    input  logic     reset_n,
    rc4_ksa_if.slave bus
);

    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    localparam logic [ADDR_W-1:0] A_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] I_LAST = {ADDR_W{1'b1}};
    localparam logic [KW-1:0]     K_ZERO = {KW{1'b0}};
    localparam logic [KW-1:0]     K_ONE  = KW'(1);
    localparam logic [KW-1:0]     K_LAST = KW'(KEY_BYTES - 1);

    // Terminal counts of the two wait phases (counter starts at 0)
    localparam logic [1:0] WAIT_I_LAST = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;
    localparam logic [1:0] WAIT_J_LAST = 2'(RD_LAT - 1);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_RI     = 4'd1,
        ST_WAIT_I = 4'd2,
        ST_CI     = 4'd3,
        ST_WAIT_J = 4'd4,
        ST_CJ     = 4'd5,
        ST_WI     = 4'd6,
        ST_WJ     = 4'd7,
        ST_DONE   = 4'd8
`ifdef RC4_KSA_INIT_FILL_EN
        , ST_INIT = 4'd9
`endif
    } state_t;

    // Selects key byte idx (byte 0 is the MSB) and fits it to ADDR_W bits:
    // zero-extended when ADDR_W > 8, truncated when ADDR_W < 8.
    function automatic logic [ADDR_W-1:0] key_byte(
        input logic [KEY_BYTES*8-1:0] key,
        input logic [KW-1:0]          idx
    );
        logic [7:0]        b;
        logic [ADDR_W+7:0] ext;
        b = 8'h00;
        for (int n = 0; n < KEY_BYTES; n++) begin
            b = (idx == KW'(n)) ? key[(KEY_BYTES-1-n)*8 +: 8] : b;
        end
        ext = {{ADDR_W{1'b0}}, b};
        return ext[ADDR_W-1:0];
    endfunction

    state_t                 state_r,   state_s;
    logic [ADDR_W-1:0]      i_r,       i_s;
    logic [ADDR_W-1:0]      j_r,       j_s;
    logic [KW-1:0]          k_r,       k_s;
    logic [ADDR_W-1:0]      si_r,      si_s;
    logic [KEY_BYTES*8-1:0] key_r,     key_s;
    logic [1:0]             wait_r,    wait_s;
    logic [ADDR_W-1:0]      address_r, address_s;
    logic [ADDR_W-1:0]      data_r,    data_s;
    logic                   wren_r,    wren_s;
    logic                   busy_r,    busy_s;
    logic                   finish_r,  finish_s;
    logic [ADDR_W-1:0]      j_new_s;

    // New j for the CI cycle: j + S[i] + key byte, wrapping mod 2**ADDR_W
    always_comb begin
        j_new_s = j_r + bus.q + key_byte(key_r, k_r);
    end

    // Next-state and next-output logic of the KSA sequencer
    always_comb begin
        state_s   = state_r;
        i_s       = i_r;
        j_s       = j_r;
        k_s       = k_r;
        si_s      = si_r;
        key_s     = key_r;
        wait_s    = wait_r;
        address_s = address_r;
        data_s    = data_r;
        wren_s    = 1'b0;
        busy_s    = busy_r;
        finish_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    key_s     = bus.secret_key;
                    i_s       = A_ZERO;
                    j_s       = A_ZERO;
                    k_s       = K_ZERO;
                    busy_s    = 1'b1;
                    address_s = A_ZERO;
`ifdef RC4_KSA_INIT_FILL_EN
                    // First fill write S[0] = 0 goes out with the INIT entry
                    data_s    = A_ZERO;
                    wren_s    = 1'b1;
                    state_s   = ST_INIT;
`else
                    state_s   = ST_RI;
`endif
                end else begin
                    busy_s    = 1'b0;
                    address_s = A_ZERO;
                    data_s    = A_ZERO;
                end
            end

`ifdef RC4_KSA_INIT_FILL_EN
            // i doubles as the fill index; it is back at 0 for the first RI
            ST_INIT: begin
                if (i_r == I_LAST) begin
                    i_s       = A_ZERO;
                    address_s = A_ZERO;
                    state_s   = ST_RI;
                end else begin
                    i_s       = i_r + A_ONE;
                    address_s = i_r + A_ONE;
                    data_s    = i_r + A_ONE;
                    wren_s    = 1'b1;
                end
            end
`endif

            ST_RI: begin
                wait_s  = 2'd0;
                state_s = (RD_LAT > 1) ? ST_WAIT_I : ST_CI;
            end

            ST_WAIT_I: begin
                if (wait_r == WAIT_I_LAST) begin
                    state_s = ST_CI;
                end else begin
                    wait_s  = wait_r + 2'd1;
                end
            end

            ST_CI: begin
                si_s      = bus.q;
                j_s       = j_new_s;
                address_s = j_new_s;
                wait_s    = 2'd0;
                state_s   = ST_WAIT_J;
            end

            ST_WAIT_J: begin
                if (wait_r == WAIT_J_LAST) begin
                    state_s = ST_CJ;
                end else begin
                    wait_s  = wait_r + 2'd1;
                end
            end

            // S[j] is taken straight from q into the write-data register
            ST_CJ: begin
                address_s = i_r;
                data_s    = bus.q;
                wren_s    = 1'b1;
                state_s   = ST_WI;
            end

            ST_WI: begin
                address_s = j_r;
                data_s    = si_r;
                wren_s    = 1'b1;
                state_s   = ST_WJ;
            end

            // Loop control is folded into the second write cycle
            ST_WJ: begin
                if (i_r == I_LAST) begin
                    address_s = A_ZERO;
                    data_s    = A_ZERO;
                    finish_s  = 1'b1;
                    state_s   = ST_DONE;
                end else begin
                    i_s       = i_r + A_ONE;
                    k_s       = (k_r == K_LAST) ? K_ZERO : (k_r + K_ONE);
                    address_s = i_r + A_ONE;
                    state_s   = ST_RI;
                end
            end

            // start is not sampled here, so a request during DONE is dropped
            ST_DONE: begin
                busy_s    = 1'b0;
                address_s = A_ZERO;
                data_s    = A_ZERO;
                state_s   = ST_IDLE;
            end

            default: begin
                busy_s    = 1'b0;
                address_s = A_ZERO;
                data_s    = A_ZERO;
                state_s   = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any run immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            i_r       <= A_ZERO;
            j_r       <= A_ZERO;
            k_r       <= K_ZERO;
            si_r      <= A_ZERO;
            key_r     <= {(KEY_BYTES*8){1'b0}};
            wait_r    <= 2'd0;
            address_r <= A_ZERO;
            data_r    <= A_ZERO;
            wren_r    <= 1'b0;
            busy_r    <= 1'b0;
            finish_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            i_r       <= i_s;
            j_r       <= j_s;
            k_r       <= k_s;
            si_r      <= si_s;
            key_r     <= key_s;
            wait_r    <= wait_s;
            address_r <= address_s;
            data_r    <= data_s;
            wren_r    <= wren_s;
            busy_r    <= busy_s;
            finish_r  <= finish_s;
        end
    end

    assign bus.address = address_r;
    assign bus.data    = data_r;
    assign bus.wren    = wren_r;
    assign bus.busy    = busy_r;
    assign bus.finish  = finish_r;

endmodule
